// File: rtl/sextium_mem_bridge.sv
// Memory-side bridge between the Sextium core memory port and an asynchronous SRAM.
// Runs setup / access / ack / recover phases with a configurable number of wait states.
module sextium_mem_bridge #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       addr_bus,
    input  logic [15:0]       mem_bus_out,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [15:0]       mem_bus_in,
    output logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StAck, StRecover} state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic       latch;
    logic       capture;
    logic       ce_n_d, oe_n_d, we_n_d, dq_oe_d, ack_d;

    // Upper core address bits are intentionally dropped when ADDR_W < 16.
    logic unused_addr;
    assign unused_addr = ^addr_bus;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        latch   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    state_d = StSetup;
                    wr_d    = mem_write;
                    latch   = 1'b1;
                end
            end
            StSetup: begin
                cnt_d   = WaitInit;
                state_d = StAccess;
                ce_n_d  = 1'b0;
                oe_n_d  = wr_q;
                dq_oe_d = wr_q;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
                ce_n_d  = 1'b0;
                we_n_d  = ~wr_q;
                oe_n_d  = wr_q;
                dq_oe_d = wr_q;
            end
            StAck: begin
                state_d = StRecover;
                ack_d   = 1'b1;
                dq_oe_d = wr_q;
            end
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Strobes are registered from the current state, so they trail the state by one edge;
    // read data is captured on the edge that closes the visible access window.
    assign capture = (state_q == StAck) && !wr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            mem_bus_in  <= 16'h0000;
            mem_ack     <= 1'b0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 16'h0000;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            mem_ack    <= ack_d;
            busy       <= (state_d != StIdle);
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            if (latch) begin
                sram_addr   <= addr_bus[ADDR_W-1:0];
                sram_dq_out <= mem_bus_out;
            end
            if (capture) begin
                mem_bus_in <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sextium_mem_bridge.sv
// Directed bench for sextium_mem_bridge: one instance with two wait states and 16-bit SRAM
// address, one with zero wait states and 8-bit SRAM address, each backed by a small RAM model.
module tb_sextium_mem_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr_bus = 16'h0;
    logic [15:0] mem_bus_out = 16'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;

    logic [15:0] mbi2, dqo2, dqi2, sa2;
    logic        ack2, busy2, dqoe2, ce2, oe2, we2;
    logic [15:0] mbi0, dqo0, dqi0;
    logic [7:0]  sa0;
    logic        ack0, busy0, dqoe0, ce0, oe0, we0;

    logic [15:0] ram2 [0:4095];
    logic [15:0] ram0 [0:255];

    always #5 clock = ~clock;

    sextium_mem_bridge #(.WAIT_CYCLES(2), .ADDR_W(16)) dut2 (
        .clock(clock), .reset(reset), .addr_bus(addr_bus), .mem_bus_out(mem_bus_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_bus_in(mbi2), .mem_ack(ack2),
        .busy(busy2), .sram_addr(sa2), .sram_dq_out(dqo2), .sram_dq_in(dqi2),
        .sram_dq_oe(dqoe2), .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2)
    );

    sextium_mem_bridge #(.WAIT_CYCLES(0), .ADDR_W(8)) dut0 (
        .clock(clock), .reset(reset), .addr_bus(addr_bus), .mem_bus_out(mem_bus_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_bus_in(mbi0), .mem_ack(ack0),
        .busy(busy0), .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_in(dqi0),
        .sram_dq_oe(dqoe0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
    );

    // Asynchronous SRAM models: write while ce_n/we_n low, read data driven while ce_n/oe_n low.
    assign dqi2 = (!ce2 && !oe2) ? ram2[sa2[11:0]] : 16'h0000;
    assign dqi0 = (!ce0 && !oe0) ? ram0[sa0] : 16'h0000;

    always @(posedge clock) begin
        if (reset && !mon_en) begin
            ram0[1] <= 16'hA001;
            ram0[2] <= 16'hB002;
        end
        if (!ce2 && !we2) ram2[sa2[11:0]] <= dqo2;
        if (!ce0 && !we0) ram0[sa0] <= dqo0;
    end

    // Strobe exclusivity monitor, checked once at the end.
    logic mon_en = 1'b0;
    logic viol   = 1'b0;
    always @(negedge clock) begin
        if (mon_en) begin
            if ((!oe2 && !we2) || (dqoe2 && !oe2) || (!oe0 && !we0) || (dqoe0 && !oe0))
                viol <= 1'b1;
        end
    end

    // Observation mux: use0 selects the zero-wait instance.
    logic        use0 = 1'b0;
    logic        m_ack, m_we, m_oe, m_dqoe;
    logic [15:0] m_addr, m_dqo, m_mbi;
    assign m_ack  = use0 ? ack0  : ack2;
    assign m_we   = use0 ? we0   : we2;
    assign m_oe   = use0 ? oe0   : oe2;
    assign m_dqoe = use0 ? dqoe0 : dqoe2;
    assign m_addr = use0 ? {8'h00, sa0} : sa2;
    assign m_dqo  = use0 ? dqo0  : dqo2;
    assign m_mbi  = use0 ? mbi0  : mbi2;

    int n_tests = 0;
    int n_fail  = 0;

    int          r_ack_cnt, r_ack_k, r_we, r_oe, r_oe_first;
    logic [15:0] r_data, r_addr0, r_dout0;
    logic        r_dqoe_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one request and watch the selected instance for 12 edges; k=0 is the sampling edge.
    task automatic run(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        r_ack_cnt = 0; r_ack_k = -1; r_we = 0; r_oe = 0; r_oe_first = -1;
        r_data = 16'h0; r_addr0 = 16'h0; r_dout0 = 16'h0; r_dqoe_ack = 1'b0;
        addr_bus = a; mem_bus_out = d; mem_read = rd; mem_write = wr;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) begin
                r_addr0 = m_addr;
                r_dout0 = m_dqo;
            end
            if (!m_we) r_we++;
            if (!m_oe) begin
                r_oe++;
                if (r_oe_first < 0) r_oe_first = k;
            end
            if (m_ack) begin
                r_ack_cnt++;
                if (r_ack_k < 0) begin
                    r_ack_k    = k;
                    r_data     = m_mbi;
                    r_dqoe_ack = m_dqoe;
                end
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
    endtask

    initial begin
        int          acks;
        int          ack_k [2];
        logic [15:0] ack_d [2];
        logic        raised;

        // 1. Reset
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        check("rst_ce_n",  32'(ce2),   32'd1);
        check("rst_oe_n",  32'(oe2),   32'd1);
        check("rst_we_n",  32'(we2),   32'd1);
        check("rst_dq_oe", 32'(dqoe2), 32'd0);
        check("rst_ack",   32'(ack2),  32'd0);
        check("rst_mbi",   32'(mbi2),  32'h0);
        check("rst_busy",  32'(busy2), 32'd0);
        check("rst_addr",  32'(sa2),   32'h0);
        check("rst_dqo",   32'(dqo2),  32'h0);

        // 2. Write with two wait states
        use0 = 1'b0;
        run(1'b0, 1'b1, 16'h0123, 16'hBEEF);
        check("wr_addr",    32'(r_addr0),    32'h0123);
        check("wr_dout",    32'(r_dout0),    32'hBEEF);
        check("wr_we_cnt",  32'(r_we),       32'd3);
        check("wr_oe_cnt",  32'(r_oe),       32'd0);
        check("wr_ack_cnt", 32'(r_ack_cnt),  32'd1);
        check("wr_ack_k",   32'(r_ack_k),    32'd5);
        check("wr_dqoe_ack", 32'(r_dqoe_ack), 32'd1);
        check("wr_ram",     32'(ram2[12'h123]), 32'hBEEF);
        idle(4);

        // 3. Read back, then a write must not disturb mem_bus_in
        run(1'b1, 1'b0, 16'h0123, 16'h0000);
        check("rd_oe_cnt",   32'(r_oe),       32'd4);
        check("rd_oe_first", 32'(r_oe_first), 32'd1);
        check("rd_we_cnt",   32'(r_we),       32'd0);
        check("rd_ack_k",    32'(r_ack_k),    32'd5);
        check("rd_data",     32'(r_data),     32'hBEEF);
        idle(4);
        run(1'b0, 1'b1, 16'h0200, 16'h5555);
        check("hold_ack_cnt", 32'(r_ack_cnt), 32'd1);
        check("hold_mbi",     32'(mbi2),      32'hBEEF);
        idle(4);

        // 4. Zero wait states, back-to-back reads dropped in the ACK cycle
        use0 = 1'b1;
        acks = 0; raised = 1'b0;
        ack_k[0] = -1; ack_k[1] = -1; ack_d[0] = 16'h0; ack_d[1] = 16'h0;
        addr_bus = 16'h0001; mem_read = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (m_ack) begin
                if (acks < 2) begin
                    ack_k[acks] = k;
                    ack_d[acks] = m_mbi;
                end
                acks++;
                mem_read = 1'b0;
            end else if (acks == 1 && !raised) begin
                raised   = 1'b1;
                addr_bus = 16'h0002;
                mem_read = 1'b1;
            end
        end
        mem_read = 1'b0;
        check("b2b_acks",   32'(acks),     32'd2);
        check("b2b_ack0_k", 32'(ack_k[0]), 32'd3);
        check("b2b_data0",  32'(ack_d[0]), 32'hA001);
        check("b2b_ack1_k", 32'(ack_k[1]), 32'd8);
        check("b2b_data1",  32'(ack_d[1]), 32'hB002);
        idle(6);

        // Address wrap on the 8-bit SRAM
        run(1'b0, 1'b1, 16'h01FF, 16'hC0DE);
        check("wrap_addr",   32'(r_addr0),     32'h00FF);
        check("wrap_we_cnt", 32'(r_we),        32'd1);
        check("wrap_ack_k",  32'(r_ack_k),     32'd3);
        check("wrap_ram",    32'(ram0[8'hFF]), 32'hC0DE);
        idle(6);

        // 5. Both requests high is a write
        use0 = 1'b0;
        run(1'b1, 1'b1, 16'h0042, 16'h1234);
        check("both_we_cnt",  32'(r_we),          32'd3);
        check("both_oe_cnt",  32'(r_oe),          32'd0);
        check("both_ack_cnt", 32'(r_ack_cnt),     32'd1);
        check("both_ram",     32'(ram2[12'h042]), 32'h1234);
        idle(6);

        // 6. Reset during the second ACCESS cycle of a write
        acks = 0;
        addr_bus = 16'h0300; mem_bus_out = 16'h7777; mem_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack2) acks++;
        end
        check("abort_in_access", 32'(we2), 32'd0);
        reset = 1'b1;
        mem_write = 1'b0;
        tick();
        check("abort_we_n",  32'(we2),   32'd1);
        check("abort_ce_n",  32'(ce2),   32'd1);
        check("abort_dq_oe", 32'(dqoe2), 32'd0);
        check("abort_busy",  32'(busy2), 32'd0);
        check("abort_mbi",   32'(mbi2),  32'h0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ack2) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        run(1'b1, 1'b0, 16'h0123, 16'h0000);
        check("post_ack_cnt", 32'(r_ack_cnt), 32'd1);
        check("post_data",    32'(r_data),    32'hBEEF);
        idle(4);

        check("strobe_excl", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
